// File: rtl/jtag_types_pkg.sv
// Shared JTAG types for the TAP and its data-register helpers.
// Holds the TMP controller state encoding and status width.
package jtag_types_pkg;

  typedef enum logic [1:0] {
    TMP_IDLE     = 2'd0,
    TMP_HOLD     = 2'd1,
    TMP_REL_PEND = 2'd2
  } tmp_state_t;

  localparam int TMP_STATUS_W = 2;

endpackage

// File: rtl/tmp_status_reg.sv
// Capture/shift data register for TMP_STATUS.
// Shifts right toward tdo; tdi enters at the MSB.
module tmp_status_reg #(
  parameter int W = 2
) (
  input  logic         TCK,
  input  logic         TRST,
  input  logic         capture,
  input  logic         shift,
  input  logic         tdi,
  input  logic [W-1:0] par_in,
  output logic         tdo
);

  logic [W-1:0] q;

  // Capture wins over shift; otherwise the value holds.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      q <= '0;
    end else if (capture) begin
      q <= par_in;
    end else if (shift) begin
      q <= {tdi, q[W-1:1]};
    end
  end

  assign tdo = q[0];

endmodule

// File: rtl/tmp_controller.sv
// Test Mode Persistence controller for the JTAG TAP.
// Keeps bsr_mode asserted across TLR once CLAMP_HOLD loads.
module tmp_controller
  import jtag_types_pkg::*;
#(
  parameter int STATUS_W = TMP_STATUS_W
) (
  input  logic TCK,
  input  logic TRST,
  input  logic tlr,
  input  logic update_ir,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic tdi,
  input  logic clamp_hold_decode,
  input  logic clamp_release_decode,
  input  logic bypass_decode,
  input  logic tmp_select,
  input  logic ir_test_mode,
  output logic bsr_mode,
  output logic persist_active,
  output logic tmp_tdo
);

  tmp_state_t state_q;
  tmp_state_t state_d;
  logic       test_mode_q;
  logic       test_mode_d;
  logic [STATUS_W-1:0] status_in;

  // BYPASS needs no dedicated path: any
  // non-clamp instruction ends a pending release.
  logic unused_bypass;
  assign unused_bypass = bypass_decode;

  // Next state and test-mode; tlr masks update_ir.
  always_comb begin
    state_d     = state_q;
    test_mode_d = test_mode_q;
    if (tlr) begin
      if (state_q != TMP_HOLD) begin
        test_mode_d = 1'b0;
      end
      if (state_q == TMP_REL_PEND) begin
        state_d = TMP_IDLE;
      end
    end else if (update_ir) begin
      test_mode_d = ir_test_mode;
      case (state_q)
        TMP_IDLE: begin
          if (clamp_hold_decode) begin
            state_d = TMP_HOLD;
          end
        end
        TMP_HOLD: begin
          if (clamp_release_decode &&
              !clamp_hold_decode) begin
            state_d = TMP_REL_PEND;
          end
        end
        TMP_REL_PEND: begin
          if (clamp_hold_decode) begin
            state_d = TMP_HOLD;
          end else if (!clamp_release_decode) begin
            state_d = TMP_IDLE;
          end
        end
        default: state_d = TMP_IDLE;
      endcase
    end
  end

  // State and registered outputs, one cycle after the strobe.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q        <= TMP_IDLE;
      test_mode_q    <= 1'b0;
      bsr_mode       <= 1'b0;
      persist_active <= 1'b0;
    end else begin
      state_q        <= state_d;
      test_mode_q    <= test_mode_d;
      bsr_mode       <= (state_d != TMP_IDLE) | test_mode_d;
      persist_active <= (state_d != TMP_IDLE);
    end
  end

  // Status snapshot uses the pre-edge state.
  always_comb begin
    status_in    = '0;
    status_in[0] = (state_q != TMP_IDLE);
    status_in[1] = (state_q == TMP_REL_PEND);
  end

  tmp_status_reg #(
    .W(STATUS_W)
  ) u_status (
    .TCK    (TCK),
    .TRST   (TRST),
    .capture(capture_dr & tmp_select),
    .shift  (shift_dr & tmp_select),
    .tdi    (tdi),
    .par_in (status_in),
    .tdo    (tmp_tdo)
  );

endmodule

// File: doc/tmp_controller.md
Name: tmp_controller

Overview:
- Test Mode Persistence (TMP) controller for the JTAG TAP.
- Consumes the instruction decoder's TMP strobes (clamp_hold_decode, clamp_release_decode, bypass_decode, tmp_select) and the TAP state strobes.
- Owns boundary-scan test-mode persistence: once CLAMP_HOLD is loaded, bsr_mode stays asserted across Test-Logic-Reset until a CLAMP_RELEASE sequence completes.
- Provides the TMP_STATUS data register shifted on TDO when tmp_select is active.

Parameters:
- STATUS_W, 2, width of the TMP_STATUS shift register; bit0 = persistence active, bit1 = release pending, bits above 1 capture 0.

Ports:
- TCK  input  1  TAP clock; all state changes on rising edge.
- TRST  input  1  synchronous, active-high reset; the only event that clears persistence unconditionally.
- tlr  input  1  TAP is in Test-Logic-Reset this cycle.
- update_ir  input  1  one-cycle Update-IR strobe; decoder outputs are valid for the new instruction in this cycle.
- capture_dr  input  1  Capture-DR strobe.
- shift_dr  input  1  Shift-DR strobe.
- tdi  input  1  serial data in.
- clamp_hold_decode  input  1  decoder: CLAMP_HOLD is the current instruction.
- clamp_release_decode  input  1  decoder: CLAMP_RELEASE is the current instruction.
- bypass_decode  input  1  decoder: BYPASS is the current instruction.
- tmp_select  input  1  decoder: TMP_STATUS register selected.
- ir_test_mode  input  1  decoder: current instruction drives pins from the BSR (EXTEST/CLAMP class).
- bsr_mode  output  1  registered; 1 = BSR drives pins.
- persist_active  output  1  registered; 1 in TMP_HOLD or TMP_REL_PEND.
- tmp_tdo  output  1  TMP_STATUS serial out (LSB of the shift register).

Behaviour:
- Reset (TRST=1 at edge): state = TMP_IDLE; test_mode_q = 0; status shift register = 0; bsr_mode = 0; persist_active = 0; tmp_tdo = 0. TRST takes priority over all other inputs.
- State machine (tmp_state_t), evaluated on the TCK edge; event priority is TRST > tlr > update_ir.
- TMP_IDLE:
  - update_ir & clamp_hold_decode -> TMP_HOLD.
  - Otherwise stay.
- TMP_HOLD:
  - tlr is ignored; stay.
  - update_ir & clamp_release_decode -> TMP_REL_PEND.
  - update_ir with any other instruction, including BYPASS and CLAMP_HOLD: stay.
- TMP_REL_PEND:
  - tlr -> TMP_IDLE.
  - update_ir & clamp_hold_decode -> TMP_HOLD.
  - update_ir & clamp_release_decode -> stay.
  - update_ir with any other instruction (bypass_decode included) -> TMP_IDLE.
- test_mode_q:
  - On update_ir, loads ir_test_mode.
  - On tlr, clears to 0, except that the tlr clear is suppressed while state is TMP_HOLD.
- Output timing:
  - bsr_mode register is loaded each cycle with (next_state != TMP_IDLE) | next_test_mode_q. It is therefore visible 1 cycle after the causing strobe.
  - persist_active register is loaded with (next_state != TMP_IDLE), with the same 1-cycle latency.
- Clamp/decode conflicts:
  - Simultaneous clamp_hold_decode and clamp_release_decode are illegal from the decoder. If both are asserted, hold wins.
  - tlr and update_ir asserted in the same cycle: tlr wins and update_ir is ignored.
- TMP_STATUS register:
  - capture_dr & tmp_select: load {0..., state==TMP_REL_PEND, state!=TMP_IDLE}, using the current, pre-edge state.
  - shift_dr & tmp_select: shift right; MSB <= tdi.
  - capture_dr has priority over shift_dr.
  - tmp_tdo = shift register bit0 at all times.
  - Without tmp_select, the register holds its value.
- State changes during a DR shift do not alter the already captured register.

Decomposition:
- jtag_types_pkg gets tmp_state_t: TMP_IDLE, TMP_HOLD, TMP_REL_PEND (2-bit enum).
- jtag_types_pkg gets TMP_STATUS_W = 2, used as the STATUS_W default.
- One sub-module: tmp_status_reg, a parameterised capture/shift register (TCK, TRST, capture, shift, tdi, par_in, tdo).

Test Plan:
- TRST for 2 cycles, then idle -> bsr_mode=0, persist_active=0, tmp_tdo=0.
- update_ir with clamp_hold_decode=1, ir_test_mode=1; then 5 cycles of tlr=1 -> bsr_mode=1 and persist_active=1 from the cycle after update_ir, held through tlr.
- From HOLD: update_ir CLAMP_RELEASE, then update_ir BYPASS (ir_test_mode=0) -> after release, persist_active=1 and status capture reads 2'b11. After BYPASS, bsr_mode=0 and persist_active=0 one cycle later.
- From REL_PEND: tlr=1 -> IDLE next cycle, bsr_mode=0. Separately, from REL_PEND: update_ir CLAMP_HOLD -> back in HOLD, capture reads 2'b01.
- In HOLD: capture_dr & tmp_select, then 2 shift_dr cycles with tdi=1,0 -> tmp_tdo sequence 1,0; register ends at 2'b01.
- In HOLD: assert TRST together with tlr and update_ir -> all outputs 0 next cycle, state TMP_IDLE.
